// File: rtl/pipeline_stage_ctrlr_pkg.sv
// pipeline_ctrl_pkg: shared encodings for the pipeline stage controller
//   state_t  : controller FSM states
//   act_t    : per-cycle pipeline action chosen by the FSM
//   EN_*     : bit positions inside the {pc,fd,de,em,mw} enable vector
//   act_en() : enable vector implied by an action
package pipeline_ctrl_pkg;

    localparam int TIMEOUT_DEF = 16;
    localparam int CNT_W_DEF   = 16;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } state_t;

    localparam int EN_PC = 4;
    localparam int EN_FD = 3;
    localparam int EN_DE = 2;
    localparam int EN_EM = 1;
    localparam int EN_MW = 0;

    typedef enum logic [2:0] {
        ACT_OFF,
        ACT_ADVANCE,
        ACT_FLUSH,
        ACT_BUBBLE,
        ACT_DRAIN,
        ACT_FREEZE
    } act_t;

    // Each action freezes a prefix of the pipe: FREEZE holds pc..em,
    // BUBBLE holds pc/fd, DRAIN holds only pc.
    function automatic logic [4:0] act_en(act_t a);
        logic [4:0] e;
        e        = '0;
        e[EN_MW] = a != ACT_OFF;
        e[EN_EM] = a != ACT_OFF && a != ACT_FREEZE;
        e[EN_DE] = e[EN_EM];
        e[EN_FD] = e[EN_EM] && a != ACT_BUBBLE;
        e[EN_PC] = e[EN_FD] && a != ACT_DRAIN;
        return e;
    endfunction

endpackage

// File: rtl/pipeline_stage_ctrlr_if.sv
// pipeline_stage_ctrlr_if: hazard/memory status in, stage control and status out
//   master : datapath side, drives hazard/memory status, receives control
//   slave  : controller side
interface pipeline_stage_ctrlr_if
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             w_stall;
    logic             w_branch_taken;
    logic             w_halt;
    logic             w_imem_ack;
    logic             w_dmem_req;
    logic             w_dmem_ack;
    logic [4:0]       w_stage_en_5;
    logic [3:0]       w_valid_4;
    logic [1:0]       w_state_2;
    logic             w_halted;
    logic             w_mem_err;
    logic [CNT_W-1:0] w_stall_cnt;
    logic [CNT_W-1:0] w_flush_cnt;

    modport master (
        output w_stall, w_branch_taken, w_halt, w_imem_ack, w_dmem_req, w_dmem_ack,
        input  w_stage_en_5, w_valid_4, w_state_2, w_halted, w_mem_err, w_stall_cnt, w_flush_cnt
    );

    modport slave (
        input  w_stall, w_branch_taken, w_halt, w_imem_ack, w_dmem_req, w_dmem_ack,
        output w_stage_en_5, w_valid_4, w_state_2, w_halted, w_mem_err, w_stall_cnt, w_flush_cnt
    );
endinterface

// File: rtl/pipeline_stage_ctrlr_sat_counter.sv
// sat_counter: synchronous up-counter that sticks at all-ones
//   clock : clock
//   clear : synchronous clear, dominates inc
//   inc   : count one this cycle
//   count : current value
module sat_counter
    import pipeline_ctrl_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         clock,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clock) begin
        if (clear)
            count <= '0;
        else if (inc && count != '1)
            count <= count + 1'b1;
    end
endmodule

// File: rtl/pipeline_stage_ctrlr.sv
// pipeline_stage_ctrlr: stall/flush/halt controller for a 5-stage pipeline
//   clock   : rising-edge clock
//   reset_n : synchronous active-low reset
//   bus     : slave side of pipeline_stage_ctrlr_if
//             in  : w_stall, w_branch_taken, w_halt, w_imem_ack, w_dmem_req, w_dmem_ack
//             out : w_stage_en_5 {pc,fd,de,em,mw}, w_valid_4 {d,e,m,w}, w_state_2,
//                   w_halted, w_mem_err, w_stall_cnt, w_flush_cnt
module pipeline_stage_ctrlr
    import pipeline_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                  clock,
    input  logic                  reset_n,
    pipeline_stage_ctrlr_if.slave bus
);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    state_t            state, state_n;
    act_t              act;
    logic [WAIT_W-1:0] wait_cnt, wait_n;
    logic [3:0]        valid, valid_n;
    logic              mem_err, err_set;
    logic              v_d, v_e, v_m, v_w;
    logic              ev_mw, ev_br, ev_lu, ev_hl, ev_im;
    logic [4:0]        en;

    assign {v_d, v_e, v_m, v_w} = valid;

    assign ev_mw = v_m & bus.w_dmem_req & ~bus.w_dmem_ack;
    assign ev_br = v_e & bus.w_branch_taken;
    assign ev_lu = v_d & bus.w_stall;
    assign ev_hl = v_d & bus.w_halt;
    assign ev_im = ~bus.w_imem_ack;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= RUN;
            valid    <= '0;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_n;
            valid    <= valid_n;
            wait_cnt <= wait_n;
            mem_err  <= mem_err | err_set;
        end
    end

    always_comb begin
        act     = ACT_OFF;
        state_n = state;
        wait_n  = '0;
        err_set = 1'b0;
        case (state)
            RUN, MEM_WAIT: begin
                // Once waiting, only the ack releases the freeze; the releasing
                // cycle is then handled exactly like a RUN cycle.
                if (state == MEM_WAIT ? ~bus.w_dmem_ack : ev_mw) begin
                    act     = ACT_FREEZE;
                    state_n = MEM_WAIT;
                    if (state == MEM_WAIT) begin
                        wait_n = wait_cnt + 1'b1;
                        if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                            state_n = HALTED;
                            err_set = 1'b1;
                        end
                    end
                end else begin
                    // Halt and a missing fetch word both stop the PC and feed a
                    // bubble into D; only halt also starts the drain.
                    act     = ev_br ? ACT_FLUSH : ev_lu ? ACT_BUBBLE :
                              (ev_hl | ev_im) ? ACT_DRAIN : ACT_ADVANCE;
                    state_n = (~ev_br & ~ev_lu & ev_hl) ? DRAIN : RUN;
                end
            end
            DRAIN: begin
                act     = ev_mw ? ACT_FREEZE : ev_br ? ACT_FLUSH : ACT_DRAIN;
                state_n = (ev_br & ~ev_mw) ? RUN :
                          (~v_e & ~v_m & ~v_w) ? HALTED : DRAIN;
            end
            HALTED: act = ACT_OFF;
        endcase
    end

    always_comb begin
        valid_n = '0;
        case (act)
            ACT_ADVANCE: valid_n = {bus.w_imem_ack, v_d, v_e, v_m};
            ACT_FLUSH:   valid_n = {2'b00, 1'b1, v_m};
            ACT_BUBBLE:  valid_n = {v_d, 1'b0, v_e, v_m};
            ACT_DRAIN:   valid_n = {1'b0, v_d, v_e, v_m};
            ACT_FREEZE:  valid_n = {v_d, v_e, v_m, 1'b0};
            default:     valid_n = '0;
        endcase
        // A memory timeout abandons whatever is still in flight.
        if (state_n == HALTED)
            valid_n = '0;
    end

    assign en = reset_n ? act_en(act) : '0;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clock (clock),
        .clear (~reset_n),
        .inc   (~en[EN_PC] & (state == RUN | state == MEM_WAIT)),
        .count (bus.w_stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clock (clock),
        .clear (~reset_n),
        .inc   (act == ACT_FLUSH),
        .count (bus.w_flush_cnt)
    );

    assign bus.w_stage_en_5 = en;
    assign bus.w_valid_4    = valid;
    assign bus.w_state_2    = state;
    assign bus.w_halted     = state == HALTED;
    assign bus.w_mem_err    = mem_err;
endmodule

// File: tb/tb_pipeline_stage_ctrlr.sv
// tb_pipeline_stage_ctrlr: vector table, corner sequences and random run against a reference model
module tb_pipeline_stage_ctrlr;
    localparam int TO = 16;

    typedef struct packed {
        logic [6:0]  in;
        logic [4:0]  en;
        logic [3:0]  v;
        logic [1:0]  s;
        logic [15:0] sc;
        logic [15:0] fc;
    } vec_t;

    logic clock = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_pass = 0;

    int       m_state;
    logic [3:0] m_v;
    int       m_wait;
    logic     m_err;
    int       m_stall;
    int       m_flush;

    always #5 clock = ~clock;

    pipeline_stage_ctrlr_if #(.CNT_W(16)) bus ();

    pipeline_stage_ctrlr #(.TIMEOUT(TO), .CNT_W(16)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    function automatic vec_t mk(logic [6:0] in, logic [4:0] en, logic [3:0] v, logic [1:0] s, int sc, int fc);
        return {in, en, v, s, 16'(sc), 16'(fc)};
    endfunction

    // One clock cycle: in = {reset_n, stall, branch, halt, imem_ack, dmem_req, dmem_ack}.
    // Called and returning on the falling edge; the model predicts this cycle's enables
    // and the register update the coming rising edge should make.
    task automatic cyc(input logic [6:0] in, output logic [4:0] en_seen);
        logic rn, st, br, hl, ia, rq, ak, vd, ve, vm, vw, fl, to;
        logic [4:0] en;
        logic [3:0] vn;
        int sn;
        {rn, st, br, hl, ia, rq, ak} = in;
        {reset_n, bus.w_stall, bus.w_branch_taken, bus.w_halt, bus.w_imem_ack, bus.w_dmem_req, bus.w_dmem_ack} = in;
        {vd, ve, vm, vw} = m_v;
        sn = m_state;
        fl = 1'b0;
        to = 1'b0;
        if (m_state == 3) begin
            en = 5'b00000; vn = 4'b0000;
        end else if ((m_state == 1) ? !ak : (vm & rq & !ak)) begin
            en = 5'b00001; vn = {vd, ve, vm, 1'b0};
            if (m_state == 1 && m_wait + 1 >= TO) begin
                to = 1'b1; sn = 3; vn = 4'b0000;
            end else if (m_state == 0) sn = 1;
        end else if (ve & br) begin
            en = 5'b11111; vn = {2'b00, 1'b1, vm}; fl = 1'b1; sn = 0;
        end else if (m_state == 2) begin
            en = 5'b01111; vn = {1'b0, vd, ve, vm}; sn = (ve | vm | vw) ? 2 : 3;
        end else if (vd & st) begin
            en = 5'b00111; vn = {vd, 1'b0, ve, vm}; sn = 0;
        end else if ((vd & hl) | !ia) begin
            en = 5'b01111; vn = {1'b0, vd, ve, vm}; sn = (vd & hl) ? 2 : 0;
        end else begin
            en = 5'b11111; vn = {1'b1, vd, ve, vm}; sn = 0;
        end
        if (!rn) en = 5'b00000;
        #1;
        en_seen = bus.w_stage_en_5;
        check("cycle {en,valid,state,halted,err,stall_cnt,flush_cnt}",
              {bus.w_stage_en_5, bus.w_valid_4, bus.w_state_2, bus.w_halted, bus.w_mem_err, bus.w_stall_cnt, bus.w_flush_cnt},
              {en, m_v, 2'(m_state), m_state == 3, m_err, 16'(m_stall), 16'(m_flush)});
        @(posedge clock);
        if (!rn) begin
            m_state = 0; m_v = 4'b0000; m_wait = 0; m_err = 1'b0; m_stall = 0; m_flush = 0;
        end else begin
            if (!en[4] && m_state < 2 && m_stall < 65535) m_stall++;
            if (fl && m_flush < 65535) m_flush++;
            if (to) m_err = 1'b1;
            m_wait = (m_state == 1 && !ak && !to) ? m_wait + 1 : 0;
            m_state = sn;
            m_v = vn;
        end
        @(negedge clock);
    endtask

    initial begin
        vec_t tv[17];
        logic [4:0] e;
        int n;
        reset_n = 1'b0;
        {bus.w_stall, bus.w_branch_taken, bus.w_halt, bus.w_dmem_req, bus.w_dmem_ack} = '0;
        bus.w_imem_ack = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        m_state = 0; m_v = 4'b0000; m_wait = 0; m_err = 1'b0; m_stall = 0; m_flush = 0;

        tv[0]  = mk(7'b0000100, 5'b00000, 4'b0000, 2'd0, 0, 0);
        tv[1]  = mk(7'b1000100, 5'b11111, 4'b1000, 2'd0, 0, 0);
        tv[2]  = mk(7'b1000100, 5'b11111, 4'b1100, 2'd0, 0, 0);
        tv[3]  = mk(7'b1000100, 5'b11111, 4'b1110, 2'd0, 0, 0);
        tv[4]  = mk(7'b1000100, 5'b11111, 4'b1111, 2'd0, 0, 0);
        tv[5]  = mk(7'b1100100, 5'b00111, 4'b1011, 2'd0, 1, 0);
        tv[6]  = mk(7'b1000100, 5'b11111, 4'b1101, 2'd0, 1, 0);
        tv[7]  = mk(7'b1110100, 5'b11111, 4'b0010, 2'd0, 1, 1);
        tv[8]  = mk(7'b1000000, 5'b01111, 4'b0001, 2'd0, 2, 1);
        tv[9]  = mk(7'b1000100, 5'b11111, 4'b1000, 2'd0, 2, 1);
        tv[10] = mk(7'b1001100, 5'b01111, 4'b0100, 2'd2, 3, 1);
        tv[11] = mk(7'b1000100, 5'b01111, 4'b0010, 2'd2, 3, 1);
        tv[12] = mk(7'b1000100, 5'b01111, 4'b0001, 2'd2, 3, 1);
        tv[13] = mk(7'b1000100, 5'b01111, 4'b0000, 2'd2, 3, 1);
        tv[14] = mk(7'b1000100, 5'b01111, 4'b0000, 2'd3, 3, 1);
        tv[15] = mk(7'b1000100, 5'b00000, 4'b0000, 2'd3, 3, 1);
        tv[16] = mk(7'b0000100, 5'b00000, 4'b0000, 2'd0, 0, 0);
        for (int i = 0; i < 17; i++) begin
            cyc(tv[i].in, e);
            check($sformatf("vec%0d enables", i), e, tv[i].en);
            check($sformatf("vec%0d {valid,state,stall,flush}", i),
                  {bus.w_valid_4, bus.w_state_2, bus.w_stall_cnt, bus.w_flush_cnt},
                  {tv[i].v, tv[i].s, tv[i].sc, tv[i].fc});
        end

        // Data memory ack arrives on the third MEM_WAIT cycle.
        repeat (3) cyc(7'b1000100, e);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.w_state_2 == 2'd1) n++;
            cyc({6'b100011, i == 3}, e);
            if (i < 3) check($sformatf("dmem wait en c%0d", i), e, 5'b00001);
            else check("dmem ack en", e, 5'b11111);
        end
        check("dmem wait cycles", n, 3);
        check("dmem wait state after ack", bus.w_state_2, 2'd0);
        check("dmem wait stall_cnt", bus.w_stall_cnt, 16'd3);

        // Memory timeout.
        cyc(7'b0000100, e);
        repeat (3) cyc(7'b1000100, e);
        n = 0;
        for (int i = 0; i < 40 && bus.w_state_2 != 2'd3; i++) begin
            if (bus.w_state_2 == 2'd1) n++;
            cyc(7'b1000110, e);
        end
        check("timeout MEM_WAIT cycles", n, TO);
        check("timeout {state,halted,err}", {bus.w_state_2, bus.w_halted, bus.w_mem_err}, 4'b1111);
        cyc(7'b1000110, e);
        check("timeout halted en", e, 5'b00000);

        // Halt with a full pipe drains, then stops.
        cyc(7'b0000100, e);
        repeat (4) cyc(7'b1000100, e);
        check("halt pipe full", bus.w_valid_4, 4'b1111);
        cyc(7'b1001100, e);
        check("halt enters DRAIN", bus.w_state_2, 2'd2);
        for (int i = 0; i < 10 && !bus.w_halted; i++) cyc(7'b1000100, e);
        check("halt reached HALTED", {bus.w_halted, bus.w_state_2}, 3'b111);
        cyc(7'b1000100, e);
        check("halted en/valid", {e, bus.w_valid_4}, 9'd0);

        // Reset in the middle of MEM_WAIT.
        cyc(7'b0000100, e);
        repeat (3) cyc(7'b1000100, e);
        repeat (2) cyc(7'b1000110, e);
        check("mid-wait state", bus.w_state_2, 2'd1);
        cyc(7'b0000110, e);
        check("reset mid-wait", {bus.w_state_2, bus.w_valid_4, bus.w_mem_err, bus.w_stall_cnt, bus.w_flush_cnt}, 39'd0);
        cyc(7'b1000100, e);
        check("first cycle after reset en", e, 5'b11111);
        check("first cycle after reset valid", bus.w_valid_4, 4'b1000);

        for (int i = 0; i < 3000; i++) begin
            logic [6:0] r;
            r = {$urandom_range(31) != 0, $urandom_range(5) == 0, $urandom_range(4) == 0,
                 $urandom_range(19) == 0, $urandom_range(7) != 0, $urandom_range(2) == 0,
                 $urandom_range(1) == 0};
            cyc(r, e);
        end

        // Stall counter saturates rather than wrapping.
        cyc(7'b0000100, e);
        for (int i = 0; i < 65540; i++) cyc(7'b1000000, e);
        check("stall_cnt saturation", bus.w_stall_cnt, 16'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
